// File: rtl/xadc_pkg.sv
// Shared XADC definitions: DRP channel addresses, result width and the
// reader FSM state type.
package xadc_pkg;

  localparam int XADC_W = 12;

  localparam logic [6:0] TEMP   = 7'h00;
  localparam logic [6:0] VCCINT = 7'h01;
  localparam logic [6:0] VPVN   = 7'h03;

  typedef enum logic {
    IDLE,
    WAIT
  } drp_state_e;

endpackage

// File: rtl/sample_averager.sv
// Block averager: sums 2^AVG_LOG2 captured results, then emits the top eight
// bits of the truncated mean as a level with a one-cycle valid strobe.
module sample_averager
  import xadc_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [XADC_W-1:0] in_data,
  output logic [7:0]        level,
  output logic              valid
);

  localparam int ACC_W = XADC_W + AVG_LOG2;
  // A zero-length counter is illegal, so AVG_LOG2=0 keeps one bit pinned at 0.
  localparam int CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       level_q, level_d;
  logic             valid_q, valid_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    valid_d = 1'b0;
    sum     = acc_q + ACC_W'(in_data);
    if (in_valid) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        acc_d   = '0;
        level_d = 8'(sum >> (AVG_LOG2 + 4));
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = sum;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      valid_q <= valid_d;
    end
  end

  assign level = level_q;
  assign valid = valid_q;

endmodule

// File: rtl/xadc_drp_reader.sv
// DRP read sequencer: one read of CHANNEL per end-of-conversion, bounded by a
// drdy timeout, feeding captured results into the block averager.
module xadc_drp_reader
  import xadc_pkg::*;
#(
  parameter logic [6:0] CHANNEL  = VPVN,
  parameter int         AVG_LOG2 = 4,
  parameter int         TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eoc,
  output logic [6:0]        daddr,
  output logic              den,
  output logic              dwe,
  input  logic              drdy,
  input  logic [15:0]       do_in,
  output logic [XADC_W-1:0] sample,
  output logic [7:0]        level,
  output logic              valid,
  output logic              timeout_err
);

  localparam logic [7:0] TMO_INIT = 8'(TIMEOUT);

  drp_state_e        state_q, state_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              den_q, den_d;
  logic              terr_q, terr_d;
  logic [XADC_W-1:0] sample_q, sample_d;
  logic              capture;
  logic              unused_low_bits;

  assign unused_low_bits = ^do_in[3:0];

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    den_d    = 1'b0;
    terr_d   = 1'b0;
    sample_d = sample_q;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (eoc) begin
          state_d = WAIT;
          den_d   = 1'b1;
          tmo_d   = TMO_INIT;
        end
      end
      WAIT: begin
        // drdy is checked first so a response on the last allowed cycle still counts.
        if (drdy) begin
          capture  = 1'b1;
          sample_d = do_in[15:4];
          state_d  = IDLE;
        end else if (tmo_q == 8'd1) begin
          terr_d  = 1'b1;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      den_q    <= 1'b0;
      terr_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      den_q    <= den_d;
      terr_q   <= terr_d;
      sample_q <= sample_d;
    end
  end

  sample_averager #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk     (clk),
    .rst     (rst),
    .in_valid(capture),
    .in_data (do_in[15:4]),
    .level   (level),
    .valid   (valid)
  );

  assign daddr       = CHANNEL;
  assign dwe         = 1'b0;
  assign den         = den_q;
  assign timeout_err = terr_q;
  assign sample      = sample_q;

endmodule

// File: tb/tb_xadc_drp_reader.sv
// Randomised scoreboard bench for xadc_drp_reader against a block-mean model.
module tb_xadc_drp_reader;

  localparam int AVG_LOG2 = 4;
  localparam int N        = 1 << AVG_LOG2;
  localparam int TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        rst, eoc, drdy;
  logic [15:0] do_in;
  logic [6:0]  daddr;
  logic        den, dwe, valid, timeout_err;
  logic [11:0] sample;
  logic [7:0]  level;

  xadc_drp_reader #(
    .CHANNEL (7'h03),
    .AVG_LOG2(AVG_LOG2),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .eoc        (eoc),
    .daddr      (daddr),
    .den        (den),
    .dwe        (dwe),
    .drdy       (drdy),
    .do_in      (do_in),
    .sample     (sample),
    .level      (level),
    .valid      (valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int den_seen = 0, den_exp = 0;
  int to_seen = 0, to_exp = 0;
  logic [7:0]  exp_level_q[$];
  logic [11:0] block_q[$];
  logic [11:0] last_sample = '0;
  logic [7:0]  last_level  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: mean of each completed block of N results, top eight bits.
  task automatic model_capture(input logic [11:0] s);
    int sum;
    last_sample = s;
    block_q.push_back(s);
    if (block_q.size() == N) begin
      sum = 0;
      foreach (block_q[i]) sum += int'(block_q[i]);
      last_level = 8'(((sum / N) >> 4) & 255);
      exp_level_q.push_back(last_level);
      block_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (den) begin
      den_seen++;
      check("daddr", 32'(daddr), 32'h03);
      check("dwe", 32'(dwe), 32'h0);
    end
    if (timeout_err) to_seen++;
    if (valid) begin
      if (exp_level_q.size() == 0) check("valid_unexpected", 32'(valid), 32'h0);
      else check("level", 32'(level), 32'(exp_level_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_once(input logic [11:0] s, input int k);
    eoc = 1'b1;
    den_exp++;
    tick();
    eoc = 1'b0;
    repeat (k) tick();
    drdy  = 1'b1;
    do_in = {s, 4'($urandom)};
    tick();
    drdy  = 1'b0;
    do_in = 16'($urandom);
    model_capture(s);
    check("sample", 32'(sample), 32'(s));
  endtask

  task automatic read_timeout();
    eoc = 1'b1;
    den_exp++;
    to_exp++;
    tick();
    eoc = 1'b0;
    repeat (TIMEOUT + 2) tick();
    check("timeout_count", 32'(to_seen), 32'(to_exp));
    check("sample_hold", 32'(sample), 32'(last_sample));
    check("level_hold", 32'(level), 32'(last_level));
  endtask

  task automatic phase_end(input string name);
    repeat (3) tick();
    check({name, "_levels_drained"}, 32'(exp_level_q.size()), 32'h0);
    check({name, "_den_count"}, 32'(den_seen), 32'(den_exp));
    check({name, "_timeout_count"}, 32'(to_seen), 32'(to_exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    eoc   = 1'b0;
    drdy  = 1'b0;
    do_in = '0;
    repeat (3) tick();
    check("rst_den", 32'(den), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_timeout", 32'(timeout_err), 32'h0);
    check("rst_sample", 32'(sample), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < N; i++) read_once(12'hA5A, i % 3);
    check("a5_level", 32'(level), 32'hA5);
    phase_end("a5");

    for (int i = 0; i < N; i++) read_once(12'(i), 0);
    check("ramp_level", 32'(level), 32'h00);
    for (int i = 0; i < N; i++) read_once(12'hFFF, 1);
    check("full_level", 32'(level), 32'hFF);
    phase_end("ramp");

    read_timeout();
    read_once(12'h3C7, 2);
    read_once(12'h5E1, TIMEOUT - 1);
    check("boundary_no_timeout", 32'(to_seen), 32'(to_exp));
    phase_end("timeout");

    // eoc while waiting, eoc together with drdy, then a stray drdy in IDLE.
    eoc = 1'b1;
    den_exp++;
    tick();
    eoc = 1'b0;
    tick();
    eoc = 1'b1;
    tick();
    drdy  = 1'b1;
    do_in = 16'h9B20;
    tick();
    eoc   = 1'b0;
    drdy  = 1'b0;
    model_capture(12'h9B2);
    check("overlap_sample", 32'(sample), 32'h9B2);
    tick();
    drdy  = 1'b1;
    do_in = 16'h1230;
    tick();
    drdy = 1'b0;
    tick();
    check("spurious_sample", 32'(sample), 32'h9B2);
    phase_end("drop");

    // Reset in the middle of a wait; the late drdy must be ignored.
    for (int i = 0; i < 5; i++) read_once(12'($urandom), $urandom_range(0, 3));
    eoc = 1'b1;
    den_exp++;
    tick();
    eoc = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    block_q.delete();
    last_sample = '0;
    last_level  = '0;
    check("mid_rst_sample", 32'(sample), 32'h0);
    check("mid_rst_level", 32'(level), 32'h0);
    check("mid_rst_den", 32'(den), 32'h0);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_timeout", 32'(timeout_err), 32'h0);
    tick();
    drdy  = 1'b1;
    do_in = 16'hFFF0;
    tick();
    drdy = 1'b0;
    tick();
    check("late_drdy_sample", 32'(sample), 32'h0);
    for (int i = 0; i < N - 1; i++) read_once(12'($urandom), $urandom_range(0, 2));
    check("post_rst_partial_level", 32'(level), 32'h0);
    read_once(12'($urandom), 0);
    phase_end("reset");

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) == 0) read_timeout();
      else read_once(12'($urandom), $urandom_range(0, TIMEOUT - 1));
      repeat ($urandom_range(0, 2)) tick();
    end
    phase_end("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
